// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory/bus fabric (slave).
// Valid/ready request channel plus a separate rvalid read-return channel.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  bus_valid;
   logic                  bus_we;
   logic [DATA_W/8-1:0]   bus_be;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W-1:0]     bus_wdata;
   logic                  bus_ready;
   logic                  bus_rvalid;
   logic [DATA_W-1:0]     bus_rdata;

   modport master (
      output bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
      input  bus_ready, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_we, bus_be, bus_addr, bus_wdata,
      output bus_ready, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per request, stalls the pipeline meanwhile.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misalign_o.
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall_o,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_addr_lo,
   output logic [2:0]        rsp_funct3,
   output logic              misalign_o,
   mem_access_unit_if.master bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_WAIT_RD = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [1:0]        rsp_lo_q;
   logic [2:0]        rsp_f3_q;

   logic              illegal_s;
   logic              mis_s;
   logic              stall_s;
   logic              capture_s;
   logic              rsp_load_s;
   logic [3:0]        be_s;
   logic [DATA_W-1:0] wdata_s;

   // Funct3 legality: loads allow B/H/W/BU/HU, stores only B/H/W.
   always_comb begin
      illegal_s = 1'b1;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
         3'b100, 3'b101:         illegal_s = req_write;
         default:                illegal_s = 1'b1;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic mis_q;

   // Alignment check on the incoming request.
   always_comb begin
      mis_s = 1'b0;
      case (req_funct3[1:0])
         2'b01:   mis_s = req_addr[0];
         2'b10:   mis_s = |req_addr[1:0];
         default: mis_s = 1'b0;
      endcase
   end

   // One-cycle misalign pulse, visible in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= capture_s & mis_s & ~illegal_s;
      end
   end

   assign misalign_o = mis_q;
`else
   assign mis_s      = 1'b0;
   assign misalign_o = 1'b0;
`endif

   // Byte enables and lane-replicated store data; low address bits beyond the size are dropped.
   always_comb begin
      be_s    = 4'b1111;
      wdata_s = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_s    = 4'b0001 << req_addr[1:0];
            wdata_s = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{req_wdata[15:0]}};
         end
         default: begin
            be_s    = 4'b1111;
            wdata_s = req_wdata;
         end
      endcase
      if (!req_write) begin
         be_s = 4'b1111;
      end else begin
         be_s = be_s;
      end
   end

   // Next state and stall.
   always_comb begin
      state_d = state_q;
      stall_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_s = req_valid;
            if (req_valid) begin
               state_d = (illegal_s || mis_s) ? S_DONE : S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            stall_s = 1'b1;
            if (bus.bus_ready) begin
               state_d = we_q ? S_DONE : S_WAIT_RD;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT_RD: begin
            stall_s = 1'b1;
            if (bus.bus_rvalid) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT_RD;
            end
         end
         S_DONE: begin
            stall_s = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            stall_s = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign capture_s  = (state_q == S_IDLE) && req_valid;
   assign rsp_load_s = (state_q == S_WAIT_RD) && bus.bus_rvalid;

   // State, captured request and registered load response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         funct3_q    <= 3'b000;
         we_q        <= 1'b0;
         be_q        <= 4'b0000;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_lo_q    <= 2'b00;
         rsp_f3_q    <= 3'b000;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_load_s;
         if (capture_s) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_write;
            be_q     <= be_s;
            wdata_q  <= wdata_s;
         end
         if (rsp_load_s) begin
            rsp_rdata_q <= bus.bus_rdata;
            rsp_lo_q    <= addr_q[1:0];
            rsp_f3_q    <= funct3_q;
         end
      end
   end

   // Reset forces stall low even while IDLE sees a held request.
   assign stall_o       = stall_s & ~rst;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_addr_lo   = rsp_lo_q;
   assign rsp_funct3    = rsp_f3_q;

   assign bus.bus_valid = (state_q == S_REQ);
   assign bus.bus_we    = we_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, random requests vs. a spec-level model,
// and a reset-during-WAIT_RD sequence.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall_o, rsp_valid, misalign_o;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_addr_lo;
   logic [2:0]  rsp_funct3;

   mem_access_unit_if bus_if ();

   mem_access_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall_o    (stall_o),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_addr_lo(rsp_addr_lo),
      .rsp_funct3 (rsp_funct3),
      .misalign_o (misalign_o),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      int          rdy;
      int          rv;
      logic [31:0] rd;
      bit          spur;
      int          e_cyc;
      int          e_acc;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      int          e_rsp;
      int          e_mis;
   } vec_t;

   typedef struct {
      int          cyc;
      int          n_acc;
      logic [31:0] a_addr;
      logic [3:0]  a_be;
      logic        a_we;
      logic [31:0] a_wdata;
      int          n_rsp;
      logic [31:0] r_data;
      logic [1:0]  r_lo;
      logic [2:0]  r_f3;
      int          n_mis;
      int          unstable;
      int          extra;
   } obs_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_rdata = 32'h0;
   vec_t        tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected behaviour from the access rules: size in bytes, lane offset, legality, latency.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int   nb, off;
      bit   legal, mis;
      r     = v;
      legal = v.wr ? (v.f3 <= 3'd2) : (v.f3 <= 3'd2 || v.f3 == 3'd4 || v.f3 == 3'd5);
      nb    = 1 << v.f3[1:0];
      off   = ((v.addr % 4) / nb) * nb;
      mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis   = legal && ((v.addr % nb) != 0);
`endif
      r.e_wdata = 32'h0;
      r.e_addr  = v.addr - (v.addr % 4);
      r.e_be    = 4'hF;
      if (!legal || mis) begin
         r.e_cyc = 2; r.e_acc = 0; r.e_rsp = 0; r.e_mis = mis ? 1 : 0;
      end else if (v.wr) begin
         r.e_cyc = v.rdy + 3; r.e_acc = 1; r.e_rsp = 0; r.e_mis = 0;
         r.e_be  = 4'(((1 << nb) - 1) << off);
         for (int k = 0; k < 4; k++) r.e_wdata[8*k +: 8] = 8'(v.wd >> (8 * (k % nb)));
      end else begin
         r.e_cyc = v.rdy + v.rv + 4; r.e_acc = 1; r.e_rsp = 1; r.e_mis = 0;
      end
      return r;
   endfunction

   // Present one request and act as the bus slave until stall_o drops, then watch two idle cycles.
   task automatic run_access(input vec_t v, output obs_t o);
      int vcnt, wcnt;
      bit accepted, delivered, in_wait, rv;
      o = '{default: 0};
      vcnt = 0; wcnt = 0; accepted = 1'b0; delivered = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wd;
      for (int c = 0; c < 64; c++) begin
         in_wait          = accepted && !v.wr && !delivered;
         rv               = in_wait ? (wcnt >= v.rv) : v.spur;
         bus_if.bus_ready  = bus_if.bus_valid && (vcnt >= v.rdy);
         bus_if.bus_rvalid = rv;
         bus_if.bus_rdata  = (in_wait && rv) ? v.rd : $urandom();
         #1;
         o.cyc++;
         if (bus_if.bus_valid) begin
            if (vcnt == 0) begin
               o.a_addr = bus_if.bus_addr; o.a_be = bus_if.bus_be;
            end else if (bus_if.bus_addr !== o.a_addr || bus_if.bus_be !== o.a_be) begin
               o.unstable++;
            end
            if (bus_if.bus_ready) begin
               o.n_acc++; o.a_we = bus_if.bus_we; o.a_wdata = bus_if.bus_wdata;
               accepted = 1'b1;
            end
            vcnt++;
         end
         if (rsp_valid) begin
            o.n_rsp++; o.r_data = rsp_rdata; o.r_lo = rsp_addr_lo; o.r_f3 = rsp_funct3;
         end
         if (misalign_o) o.n_mis++;
         if (!stall_o) break;
         if (in_wait) begin
            if (rv) delivered = 1'b1;
            else    wcnt++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      bus_if.bus_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         bus_if.bus_rvalid = v.spur;
         bus_if.bus_rdata  = $urandom();
         #1;
         if (bus_if.bus_valid || rsp_valid || misalign_o || stall_o) o.extra++;
      end
      bus_if.bus_rvalid = 1'b0;
   endtask

   task automatic compare(input string tag, input vec_t v, input obs_t o);
      check({tag, " cycles"},  32'(o.cyc),   32'(v.e_cyc));
      check({tag, " accepts"}, 32'(o.n_acc), 32'(v.e_acc));
      if (v.e_acc > 0) begin
         check({tag, " bus_addr"}, o.a_addr, v.e_addr);
         check({tag, " bus_be"},   32'(o.a_be), 32'(v.e_be));
         check({tag, " bus_we"},   32'(o.a_we), 32'(v.wr));
         check({tag, " stable"},   32'(o.unstable), 32'h0);
         if (v.wr) check({tag, " bus_wdata"}, o.a_wdata, v.e_wdata);
      end
      check({tag, " rsp pulses"}, 32'(o.n_rsp), 32'(v.e_rsp));
      if (v.e_rsp > 0) begin
         check({tag, " rsp_rdata"},   o.r_data, v.rd);
         check({tag, " rsp_addr_lo"}, 32'(o.r_lo), 32'(v.addr[1:0]));
         check({tag, " rsp_funct3"},  32'(o.r_f3), 32'(v.f3));
         last_rdata = v.rd;
      end
      check({tag, " rsp_rdata held"}, rsp_rdata, last_rdata);
      check({tag, " misalign"}, 32'(o.n_mis), 32'(v.e_mis));
      check({tag, " after-done quiet"}, 32'(o.extra), 32'h0);
   endtask

   initial begin
      vec_t v;
      obs_t o;

      //        wr    f3      addr        wd            rdy rv rd             spur cyc acc e_addr     be     e_wdata       rsp mis
      tbl[0] = '{1'b0, 3'b010, 32'h100, 32'h0,        0, 0, 32'hA1B2C3D4, 1'b0, 4, 1, 32'h100, 4'hF, 32'h0,        1, 0};
      tbl[1] = '{1'b1, 3'b000, 32'h203, 32'h55,       0, 0, 32'h0,        1'b0, 3, 1, 32'h200, 4'h8, 32'h55555555, 0, 0};
      tbl[2] = '{1'b1, 3'b001, 32'h10,  32'h1234ABCD, 5, 0, 32'h0,        1'b0, 8, 1, 32'h10,  4'h3, 32'hABCDABCD, 0, 0};
      tbl[3] = '{1'b0, 3'b100, 32'h7,   32'h0,        0, 3, 32'hDEADBEEF, 1'b1, 7, 1, 32'h4,   4'hF, 32'h0,        1, 0};
      tbl[4] = '{1'b0, 3'b011, 32'h40,  32'h0,        0, 0, 32'h0,        1'b1, 2, 0, 32'h0,   4'h0, 32'h0,        0, 0};
      tbl[5] = '{1'b1, 3'b101, 32'h44,  32'h99,       0, 0, 32'h0,        1'b0, 2, 0, 32'h0,   4'h0, 32'h0,        0, 0};
`ifdef MISALIGN_TRAP_EN
      tbl[6] = '{1'b0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h600DF00D, 1'b0, 2, 0, 32'h0,   4'h0, 32'h0,        0, 1};
`else
      tbl[6] = '{1'b0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h600DF00D, 1'b0, 4, 1, 32'h100, 4'hF, 32'h0,        1, 0};
`endif
      tbl[7] = '{1'b1, 3'b001, 32'h12,  32'h7777BEEF, 0, 0, 32'h0,        1'b0, 3, 1, 32'h10,  4'hC, 32'hBEEFBEEF, 0, 0};
      tbl[8] = '{1'b1, 3'b010, 32'h20,  32'h11223344, 2, 0, 32'h0,        1'b0, 5, 1, 32'h20,  4'hF, 32'h11223344, 0, 0};

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
      #12;
      check("reset stall_o",   32'(stall_o), 32'h0);
      check("reset rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset rsp_meta",  32'({rsp_addr_lo, rsp_funct3, misalign_o}), 32'h0);
      check("reset bus ctrl",  32'({bus_if.bus_valid, bus_if.bus_we, bus_if.bus_be}), 32'h0);
      check("reset bus_addr",  bus_if.bus_addr, 32'h0);
      check("reset bus_wdata", bus_if.bus_wdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_access(tbl[i], o);
         compare($sformatf("vec%0d", i), tbl[i], o);
      end

      // Reset while waiting for read data, then a normal load.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
      @(negedge clk);
      bus_if.bus_ready = 1'b1;
      @(negedge clk);
      bus_if.bus_ready = 1'b0;
      #1;
      check("pre-reset in WAIT_RD stall", 32'(stall_o), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid reset bus_valid", 32'(bus_if.bus_valid), 32'h0);
      check("mid reset stall_o",   32'(stall_o), 32'h0);
      check("mid reset rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b0;
      #1;
      check("post reset stall_o", 32'(stall_o), 32'h0);
      last_rdata = 32'h0;
      v = '{1'b0, 3'b010, 32'h304, 32'h0, 1, 1, 32'hCAFE0123, 1'b1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
      v = model(v);
      run_access(v, o);
      compare("after-reset LW", v, o);

      for (int i = 0; i < 40; i++) begin
         v.wr   = 1'($urandom_range(0, 1));
         v.f3   = 3'($urandom_range(0, 7));
         v.addr = $urandom();
         v.wd   = $urandom();
         v.rdy  = $urandom_range(0, 3);
         v.rv   = $urandom_range(0, 3);
         v.rd   = $urandom();
         v.spur = 1'($urandom_range(0, 1));
         v = model(v);
         run_access(v, o);
         compare($sformatf("rand%0d", i), v, o);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
